// File: rtl/accel_sort_pkg.sv
// Shared constants for the accel_sort user-logic core: register map, control bits, stream FSM states.
package accel_sort_pkg;

  localparam int unsigned DATA_W    = 64;
  localparam int unsigned NUM_CE    = 4;
  localparam int unsigned KEY_WORD_W = 32;
  localparam int unsigned KEY_W     = 4 * KEY_WORD_W;
  localparam int unsigned CNT_W     = 32;

  // Register indices (CE position, reg0 first)
  localparam int unsigned REG_CTRL    = 0;
  localparam int unsigned REG_CMPVAL  = 1;
  localparam int unsigned REG_KEYDATA = 2;
  localparam int unsigned REG_CMD     = 3;

  // CTRL bit positions
  localparam int unsigned CTRL_IDX_CLR  = 0;
  localparam int unsigned CTRL_NO_CMP   = 1;
  localparam int unsigned CTRL_ZERO_KEY = 2;

  // CMD bit positions
  localparam int unsigned CMD_COMMIT    = 3;
  localparam int unsigned CMD_SHADOW_WR = 31;

  // Stream FSM states
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD      = 3'd1;
  localparam logic [2:0] ST_WAIT_RD = 3'd2;
  localparam logic [2:0] ST_PROC    = 3'd3;
  localparam logic [2:0] ST_WR_WAIT = 3'd4;
  localparam logic [2:0] ST_WR      = 3'd5;
  localparam logic [2:0] ST_WAIT_WR = 3'd6;

  // Stream control bits decoded from CTRL
  typedef struct packed {
    logic zero_key;
    logic no_compare;
  } ctrl_t;

endpackage

// File: rtl/accel_sort_regs.sv
// Slave register file: CE decode, CTRL/CMPVAL/KEYDATA storage, key shadow/commit and read mux.
module accel_sort_regs
  import accel_sort_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CE-1:0]     wrce,       // bit i selects register i
  input  logic [NUM_CE-1:0]     rdce,       // bit i selects register i
  input  logic [DATA_W-1:0]     wdata,
  input  logic [CNT_W-1:0]      out_count,
  output logic                  idx_clr,    // one-cycle pulse after a CTRL write with bit0 set
  output ctrl_t                 ctrl,
  output logic [DATA_W-1:0]     cmpval,
  output logic [KEY_W-1:0]      active_key, // {k0,k1,k2,k3}, k0 most significant
  output logic [DATA_W-1:0]     rdata_c
);

  logic [KEY_WORD_W-1:0]        keydata;
  logic [3:0][KEY_WORD_W-1:0]   shadow_key; // word i lives at [3-i] so k0 is the MSW
  logic [3:0][KEY_WORD_W-1:0]   active_q;

  assign active_key = active_q;

  // Register writes; commit copies the shadow value held before this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_clr    <= 1'b0;
      ctrl       <= '0;
      cmpval     <= '0;
      keydata    <= '0;
      shadow_key <= '0;
      active_q   <= '0;
    end else begin
      idx_clr <= wrce[REG_CTRL] & wdata[CTRL_IDX_CLR];
      if (wrce[REG_CTRL]) begin
        ctrl.no_compare <= wdata[CTRL_NO_CMP];
        ctrl.zero_key   <= wdata[CTRL_ZERO_KEY];
      end
      if (wrce[REG_CMPVAL]) cmpval <= wdata;
      if (wrce[REG_KEYDATA]) keydata <= wdata[KEY_WORD_W-1:0];
      if (wrce[REG_CMD]) begin
        if (wdata[CMD_SHADOW_WR]) shadow_key[2'd3 - wdata[1:0]] <= keydata;
        if (wdata[CMD_COMMIT]) active_q <= shadow_key;
      end
    end
  end

  // Read mux; CTRL bit0 always reads back as zero
  always_comb begin
    rdata_c = '0;
    if (rdce[REG_CTRL])    rdata_c = DATA_W'({ctrl.zero_key, ctrl.no_compare, 1'b0});
    if (rdce[REG_CMPVAL])  rdata_c = cmpval;
    if (rdce[REG_KEYDATA]) rdata_c = DATA_W'(keydata);
    if (rdce[REG_CMD])     rdata_c = DATA_W'(out_count);
  end

endmodule

// File: rtl/accel_sort_user_logic.sv
// accel_sort user logic: streams words from the write FIFO, XOR-decodes with the active key,
// optionally drops words equal to CMPVAL, and pushes the rest into the read FIFO.
// Bit vectors are descending; wire order keeps the legacy MSB-first numbering (reg0 CE is the MSB).
module accel_sort_user_logic
  import accel_sort_pkg::*;
#(
  parameter int unsigned C_DWIDTH        = 64,
  parameter int unsigned C_NUM_CE        = 4,
  parameter int unsigned C_RDFIFO_DWIDTH = 64,
  parameter int unsigned C_WRFIFO_DWIDTH = 64
) (
  input  logic                         bus2ip_clk,
  input  logic                         bus2ip_reset_n,
  input  logic [C_DWIDTH-1:0]          bus2ip_data,
  input  logic [C_DWIDTH/8-1:0]        bus2ip_be,
  input  logic                         bus2ip_burst,
  input  logic [C_NUM_CE-1:0]          bus2ip_rdce,
  input  logic [C_NUM_CE-1:0]          bus2ip_wrce,
  input  logic                         bus2ip_rdreq,
  input  logic                         bus2ip_wrreq,
  output logic [C_DWIDTH-1:0]          ip2bus_data,
  output logic                         ip2bus_retry,
  output logic                         ip2bus_error,
  output logic                         ip2bus_toutsup,
  output logic                         ip2bus_addrack,
  output logic                         ip2bus_busy,
  output logic                         ip2bus_rdack,
  output logic                         ip2bus_wrack,
  output logic                         ip2wfifo_rdreq,
  input  logic [C_WRFIFO_DWIDTH-1:0]   wfifo2ip_data,
  input  logic                         wfifo2ip_rdack,
  input  logic                         wfifo2ip_almostempty,
  input  logic                         wfifo2ip_empty,
  output logic                         ip2rfifo_wrreq,
  output logic [C_RDFIFO_DWIDTH-1:0]   ip2rfifo_data,
  input  logic                         rfifo2ip_wrack,
  input  logic                         rfifo2ip_almostfull,
  input  logic                         rfifo2ip_full
);

  logic [NUM_CE-1:0]  wrce, rdce;
  logic               idx_clr;
  ctrl_t              ctrl;
  logic [DATA_W-1:0]  cmpval, rdata_c, in_word, dec;
  logic [KEY_W-1:0]   active_key, key_eff;
  logic [CNT_W-1:0]   out_count;
  logic               kidx;
  logic [2:0]         state, state_nxt;
  logic               rdreq_nxt, wrreq_nxt, in_load, out_load, cnt_inc, kidx_tog;
  logic               unused_ok;

  // Reverse CE order so register i is selected by wrce[i]
  assign wrce = {<<{bus2ip_wrce}};
  assign rdce = {<<{bus2ip_rdce}};

  // Register accesses complete in the same cycle they are presented
  assign ip2bus_wrack   = |bus2ip_wrce;
  assign ip2bus_rdack   = |bus2ip_rdce;
  assign ip2bus_addrack = |(bus2ip_wrce | bus2ip_rdce);
  assign ip2bus_retry   = 1'b0;
  assign ip2bus_error   = 1'b0;
  assign ip2bus_toutsup = 1'b0;
  assign ip2bus_busy    = 1'b0;
  assign ip2bus_data    = rdata_c;

  assign unused_ok = ^{bus2ip_be, bus2ip_burst, bus2ip_rdreq, bus2ip_wrreq,
                       wfifo2ip_almostempty, rfifo2ip_almostfull};

  accel_sort_regs u_regs (
    .clk        (bus2ip_clk),
    .rst_n      (bus2ip_reset_n),
    .wrce       (wrce),
    .rdce       (rdce),
    .wdata      (bus2ip_data),
    .out_count  (out_count),
    .idx_clr    (idx_clr),
    .ctrl       (ctrl),
    .cmpval     (cmpval),
    .active_key (active_key),
    .rdata_c    (rdata_c)
  );

  // Decode with the key pair selected by the alternating index
  assign key_eff = ctrl.zero_key ? '0 : active_key;
  assign dec     = in_word ^ (kidx ? key_eff[DATA_W-1:0] : key_eff[KEY_W-1:DATA_W]);

  // Stream FSM state register
  always_ff @(posedge bus2ip_clk or negedge bus2ip_reset_n) begin
    if (!bus2ip_reset_n) state <= ST_IDLE;
    else                 state <= state_nxt;
  end

  // Next-state and datapath strobes; one outstanding request per FIFO
  always_comb begin
    state_nxt = state;
    rdreq_nxt = 1'b0;
    wrreq_nxt = 1'b0;
    in_load   = 1'b0;
    out_load  = 1'b0;
    cnt_inc   = 1'b0;
    kidx_tog  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!wfifo2ip_empty) begin
          state_nxt = ST_RD;
          rdreq_nxt = 1'b1;
        end
      end
      ST_RD, ST_WAIT_RD: begin
        if (wfifo2ip_rdack) begin
          in_load   = 1'b1;
          state_nxt = ST_PROC;
        end else begin
          state_nxt = ST_WAIT_RD;
        end
      end
      ST_PROC: begin
        kidx_tog = 1'b1;
        if (!ctrl.no_compare && (dec == cmpval)) begin
          state_nxt = ST_IDLE;
        end else begin
          out_load  = 1'b1;
          state_nxt = ST_WR_WAIT;
        end
      end
      ST_WR_WAIT: begin
        if (!rfifo2ip_full) begin
          state_nxt = ST_WR;
          wrreq_nxt = 1'b1;
        end
      end
      ST_WR, ST_WAIT_WR: begin
        if (rfifo2ip_wrack) begin
          cnt_inc   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_WAIT_WR;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered FIFO handshakes, data capture, key index and output counter
  always_ff @(posedge bus2ip_clk or negedge bus2ip_reset_n) begin
    if (!bus2ip_reset_n) begin
      ip2wfifo_rdreq <= 1'b0;
      ip2rfifo_wrreq <= 1'b0;
      ip2rfifo_data  <= '0;
      in_word        <= '0;
      kidx           <= 1'b0;
      out_count      <= '0;
    end else begin
      ip2wfifo_rdreq <= rdreq_nxt;
      ip2rfifo_wrreq <= wrreq_nxt;
      if (in_load)  in_word       <= wfifo2ip_data;
      if (out_load) ip2rfifo_data <= dec;
      if (idx_clr) begin
        kidx      <= 1'b0;
        out_count <= '0;
      end else begin
        if (kidx_tog) kidx      <= ~kidx;
        if (cnt_inc)  out_count <= out_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_accel_sort_user_logic.sv
// Scoreboard bench for accel_sort_user_logic with behavioural write/read FIFO responders.
module tb_accel_sort_user_logic;

  logic        bus2ip_clk = 1'b0;
  logic        bus2ip_reset_n;
  logic [63:0] bus2ip_data;
  logic [7:0]  bus2ip_be;
  logic        bus2ip_burst;
  logic [3:0]  bus2ip_rdce, bus2ip_wrce;
  logic        bus2ip_rdreq, bus2ip_wrreq;
  logic [63:0] ip2bus_data;
  logic        ip2bus_retry, ip2bus_error, ip2bus_toutsup, ip2bus_addrack, ip2bus_busy;
  logic        ip2bus_rdack, ip2bus_wrack;
  logic        ip2wfifo_rdreq;
  logic [63:0] wfifo2ip_data;
  logic        wfifo2ip_rdack, wfifo2ip_almostempty, wfifo2ip_empty;
  logic        ip2rfifo_wrreq;
  logic [63:0] ip2rfifo_data;
  logic        rfifo2ip_wrack, rfifo2ip_almostfull, rfifo2ip_full;

  always #5 bus2ip_clk = ~bus2ip_clk;

  accel_sort_user_logic dut (
    .bus2ip_clk(bus2ip_clk), .bus2ip_reset_n(bus2ip_reset_n),
    .bus2ip_data(bus2ip_data), .bus2ip_be(bus2ip_be), .bus2ip_burst(bus2ip_burst),
    .bus2ip_rdce(bus2ip_rdce), .bus2ip_wrce(bus2ip_wrce),
    .bus2ip_rdreq(bus2ip_rdreq), .bus2ip_wrreq(bus2ip_wrreq),
    .ip2bus_data(ip2bus_data), .ip2bus_retry(ip2bus_retry), .ip2bus_error(ip2bus_error),
    .ip2bus_toutsup(ip2bus_toutsup), .ip2bus_addrack(ip2bus_addrack), .ip2bus_busy(ip2bus_busy),
    .ip2bus_rdack(ip2bus_rdack), .ip2bus_wrack(ip2bus_wrack),
    .ip2wfifo_rdreq(ip2wfifo_rdreq), .wfifo2ip_data(wfifo2ip_data),
    .wfifo2ip_rdack(wfifo2ip_rdack), .wfifo2ip_almostempty(wfifo2ip_almostempty),
    .wfifo2ip_empty(wfifo2ip_empty),
    .ip2rfifo_wrreq(ip2rfifo_wrreq), .ip2rfifo_data(ip2rfifo_data),
    .rfifo2ip_wrack(rfifo2ip_wrack), .rfifo2ip_almostfull(rfifo2ip_almostfull),
    .rfifo2ip_full(rfifo2ip_full)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] wq[$];      // words waiting in the write FIFO
  logic [63:0] exp_q[$];   // expected read-FIFO writes, in order
  logic [31:0] keys [4] = '{32'hb01dface, 32'h0dec0ded, 32'h0ba11ade, 32'h0effec70};

  bit          go = 1'b0;
  bit          full_mode = 1'b0;
  int          rf_lat = 1;
  int          rd_lat_max = 1;
  int          full_cyc = 0;
  int          rdreq_cycles = 0;
  int          n_words = 0;
  logic        wrreq_prev = 1'b0;
  logic        full_prev = 1'b0;

  // Model state
  bit          m_kidx, m_zk, m_nocmp;
  logic [63:0] m_cmp;
  int          m_fwd;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_dec(input logic [63:0] w, input bit kidx, input bit zk);
    logic [127:0] k;
    k = zk ? 128'd0 : {keys[0], keys[1], keys[2], keys[3]};
    return w ^ (kidx ? k[63:0] : k[127:64]);
  endfunction

  task automatic push_word(input logic [63:0] w, input logic [63:0] d);
    if (m_nocmp || d != m_cmp) begin
      exp_q.push_back(d);
      m_fwd++;
    end
    m_kidx = !m_kidx;
    wq.push_back(w);
    n_words++;
  endtask

  task automatic feed(input logic [63:0] w);
    push_word(w, model_dec(w, m_kidx, m_zk));
  endtask

  task automatic reg_write(input int idx, input logic [63:0] d);
    bus2ip_data = d;
    bus2ip_wrce = '0;
    bus2ip_wrce[3-idx] = 1'b1;
    #1;
    check_eq("wrack", 64'(ip2bus_wrack), 64'd1);
    @(posedge bus2ip_clk); #1;
    bus2ip_wrce = '0;
    bus2ip_data = '0;
  endtask

  task automatic reg_read(input int idx, output logic [63:0] d);
    bus2ip_rdce = '0;
    bus2ip_rdce[3-idx] = 1'b1;
    #1;
    check_eq("rdack", 64'({ip2bus_rdack, ip2bus_addrack}), 64'd3);
    d = ip2bus_data;
    @(posedge bus2ip_clk); #1;
    bus2ip_rdce = '0;
  endtask

  task automatic set_ctrl(input logic [63:0] v);
    reg_write(0, v);
    m_kidx  = 1'b0;
    m_nocmp = v[1];
    m_zk    = v[2];
    m_fwd   = 0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || wq.size() != 0) && t < 5000) begin
      @(posedge bus2ip_clk); #1;
      t++;
    end
    check_eq("drain_left", 64'(exp_q.size() + wq.size()), 64'd0);
    repeat (10) @(posedge bus2ip_clk);
    #1;
  endtask

  // rdreq cycle count and "no wrreq issued while full" monitor
  always @(negedge bus2ip_clk) begin
    if (ip2wfifo_rdreq) rdreq_cycles++;
    if (ip2rfifo_wrreq && !wrreq_prev) check_eq("wrreq_while_full", 64'(full_prev), 64'd0);
    wrreq_prev = ip2rfifo_wrreq;
    full_prev  = rfifo2ip_full;
  end

  // Read-FIFO full pattern: 20 cycles free, 20 cycles full
  initial begin
    forever begin
      @(posedge bus2ip_clk); #1;
      if (full_mode) begin
        full_cyc++;
        rfifo2ip_full = ((full_cyc / 20) % 2) == 1;
      end else begin
        rfifo2ip_full = 1'b0;
      end
    end
  end

  // Write-FIFO responder
  initial begin
    wait (go);
    forever begin
      @(posedge bus2ip_clk); #1;
      if (ip2wfifo_rdreq) begin
        check_eq("wq_nonempty_at_rdreq", 64'(wq.size() != 0), 64'd1);
        repeat ($urandom_range(rd_lat_max, 1)) @(posedge bus2ip_clk);
        #1;
        if (wq.size() != 0) wfifo2ip_data = wq.pop_front();
        wfifo2ip_rdack = 1'b1;
        wfifo2ip_empty = (wq.size() == 0);
        @(posedge bus2ip_clk); #1;
        wfifo2ip_rdack = 1'b0;
      end
      wfifo2ip_empty = (wq.size() == 0);
    end
  end

  // Read-FIFO responder with scoreboard compare
  initial begin
    logic [63:0] d;
    wait (go);
    forever begin
      @(posedge bus2ip_clk); #1;
      if (ip2rfifo_wrreq) begin
        d = ip2rfifo_data;
        repeat (rf_lat) @(posedge bus2ip_clk);
        #1;
        check_eq("rf_data_hold", ip2rfifo_data, d);
        check_eq("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check_eq("rf_data", ip2rfifo_data, exp_q.pop_front());
        rfifo2ip_wrack = 1'b1;
        @(posedge bus2ip_clk); #1;
        rfifo2ip_wrack = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v;
    logic [63:0] w [6];
    bus2ip_reset_n = 1'b0;
    bus2ip_data = '0; bus2ip_be = '1; bus2ip_burst = 1'b0;
    bus2ip_rdce = '0; bus2ip_wrce = '0; bus2ip_rdreq = 1'b0; bus2ip_wrreq = 1'b0;
    wfifo2ip_data = '0; wfifo2ip_rdack = 1'b0; wfifo2ip_almostempty = 1'b0;
    wfifo2ip_empty = 1'b0;
    rfifo2ip_wrack = 1'b0; rfifo2ip_almostfull = 1'b0; rfifo2ip_full = 1'b0;
    m_kidx = 1'b0; m_zk = 1'b0; m_nocmp = 1'b1; m_cmp = '0; m_fwd = 0;

    // Reset held 10 cycles with the write FIFO claiming data
    repeat (10) @(posedge bus2ip_clk);
    #1;
    check_eq("rst_rdreq_cycles", 64'(rdreq_cycles), 64'd0);
    check_eq("rst_wrreq", 64'(ip2rfifo_wrreq), 64'd0);
    check_eq("rst_rf_data", ip2rfifo_data, 64'd0);
    check_eq("rst_bus_data", ip2bus_data, 64'd0);
    check_eq("rst_flags", 64'({ip2bus_retry, ip2bus_error, ip2bus_toutsup, ip2bus_busy,
                               ip2bus_rdack, ip2bus_wrack, ip2bus_addrack}), 64'd0);
    bus2ip_reset_n = 1'b1;
    wfifo2ip_empty = 1'b1;
    go = 1'b1;
    @(posedge bus2ip_clk); #1;
    reg_read(3, v);
    check_eq("cnt_after_reset", v, 64'd0);

    // Key load through KEYDATA + CMD, then commit
    for (int i = 0; i < 4; i++) begin
      reg_write(2, 64'(keys[i]));
      reg_write(3, 64'h8000_0000 | 64'(i));
    end
    reg_write(3, 64'h8);

    // zero_key pass-through
    set_ctrl(64'h7);
    for (int i = 0; i < 4; i++) feed({$urandom, $urandom});
    drain();
    reg_read(3, v);
    check_eq("cnt_passthru", v, 64'd4);

    // Key applied, no compare: zero words reveal each key pair
    set_ctrl(64'h3);
    push_word(64'd0, 64'hb01dface0dec0ded);
    push_word(64'd0, 64'h0ba11ade0effec70);
    for (int i = 0; i < 4; i++) feed({$urandom, $urandom});
    drain();
    reg_read(3, v);
    check_eq("cnt_keyed", v, 64'(m_fwd));

    // Compare enabled: word 1 decodes to CMPVAL and is dropped
    for (int i = 0; i < 6; i++) w[i] = {$urandom, $urandom};
    m_cmp = model_dec(w[1], 1'b1, 1'b0);
    reg_write(1, m_cmp);
    set_ctrl(64'h1);
    for (int i = 0; i < 6; i++) feed(w[i]);
    drain();
    reg_read(3, v);
    check_eq("cnt_drop", v, 64'd5);

    // Backpressure: full toggling 20/20, late acks on both FIFOs
    full_mode = 1'b1;
    rf_lat = 3;
    rd_lat_max = 3;
    set_ctrl(64'h3);
    for (int i = 0; i < 12; i++) feed({$urandom, $urandom});
    drain();
    full_mode = 1'b0;
    rf_lat = 1;
    rd_lat_max = 1;
    reg_read(3, v);
    check_eq("cnt_backpressure", v, 64'd12);

    // Register readback
    reg_write(1, 64'h1234);
    reg_read(1, v);
    check_eq("cmpval_rb", v, 64'h1234);
    reg_read(0, v);
    check_eq("ctrl_rb", v, 64'h2);
    reg_write(0, 64'h7);
    reg_read(0, v);
    check_eq("ctrl_rb_bit0", v, 64'h6);
    reg_read(2, v);
    check_eq("keydata_rb", v, 64'h0effec70);
    reg_read(3, v);
    check_eq("cnt_cleared", v, 64'd0);

    check_eq("rdreq_pulses", 64'(rdreq_cycles), 64'(n_words));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
